// File: rtl/nw_traceback_pkg.sv
// Shared types and constants for the Needleman-Wunsch traceback block.
package nw_traceback_pkg;

    localparam int unsigned NW_N  = 128;
    localparam int unsigned NW_CW = 2;
    localparam int unsigned NW_SW = 9;

    // Scoring scheme used when the matrix was filled.
    localparam int MATCH    = 1;
    localparam int MISMATCH = -1;
    localparam int GAP      = -2;

    // Direction codes streamed to the alignment writer.
    localparam logic [1:0] DIR_D = 2'b01;
    localparam logic [1:0] DIR_U = 2'b10;
    localparam logic [1:0] DIR_L = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_EDGE    = 3'd4,
        S_EMIT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/nw_traceback_decide.sv
// Predecessor selection for one interior cell: D over U over L, err if none fits.
module nw_traceback_decide
    import nw_traceback_pkg::*;
#(
    parameter int unsigned CW = NW_CW,
    parameter int unsigned SW = NW_SW
)(
    input  logic [SW-1:0] i_cur,
    input  logic [SW-1:0] i_diag,
    input  logic [SW-1:0] i_up,
    input  logic [SW-1:0] i_left,
    input  logic [CW-1:0] i_chr_a,
    input  logic [CW-1:0] i_chr_b,
    output logic [1:0]    o_dir_c,
    output logic          o_match_c,
    output logic          o_err_c
);

    localparam logic signed [SW-1:0] C_MATCH    = SW'(MATCH);
    localparam logic signed [SW-1:0] C_MISMATCH = SW'(MISMATCH);
    localparam logic signed [SW-1:0] C_GAP      = SW'(GAP);

    logic                 w_chr_eq;
    logic signed [SW-1:0] w_exp_d;
    logic signed [SW-1:0] w_exp_u;
    logic signed [SW-1:0] w_exp_l;
    logic                 w_hit_d;
    logic                 w_hit_u;
    logic                 w_hit_l;

    assign w_chr_eq = (i_chr_a == i_chr_b);
    assign w_exp_d  = $signed(i_diag) + (w_chr_eq ? C_MATCH : C_MISMATCH);
    assign w_exp_u  = $signed(i_up) + C_GAP;
    assign w_exp_l  = $signed(i_left) + C_GAP;
    assign w_hit_d  = ($signed(i_cur) == w_exp_d);
    assign w_hit_u  = ($signed(i_cur) == w_exp_u);
    assign w_hit_l  = ($signed(i_cur) == w_exp_l);

    // Priority select; an unexplainable score still yields L so the walk ends.
    always_comb begin
        o_dir_c   = DIR_L;
        o_match_c = 1'b0;
        o_err_c   = 1'b0;
        if (w_hit_d) begin
            o_dir_c   = DIR_D;
            o_match_c = w_chr_eq;
        end else if (w_hit_u) begin
            o_dir_c   = DIR_U;
        end else if (w_hit_l) begin
            o_dir_c   = DIR_L;
        end else begin
            o_err_c   = 1'b1;
        end
    end

endmodule

// File: rtl/nw_traceback.sv
// Walks the filled score matrix from (len_a,len_b) to (0,0), one step per handshake.
module nw_traceback
    import nw_traceback_pkg::*;
#(
    parameter  int unsigned N  = NW_N,
    parameter  int unsigned CW = NW_CW,
    parameter  int unsigned SW = NW_SW,
    localparam int unsigned IW = $clog2(N) + 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [IW-1:0] i_len_a,
    input  logic [IW-1:0] i_len_b,
    output logic          o_rd_en,
    output logic [IW-1:0] o_rd_i,
    output logic [IW-1:0] o_rd_j,
    input  logic [SW-1:0] i_rd_cur,
    input  logic [SW-1:0] i_rd_diag,
    input  logic [SW-1:0] i_rd_up,
    input  logic [SW-1:0] i_rd_left,
    input  logic [CW-1:0] i_chr_a,
    input  logic [CW-1:0] i_chr_b,
    output logic          o_step_valid,
    input  logic          i_step_ready,
    output logic [1:0]    o_step_dir,
    output logic          o_step_match,
    output logic          o_step_last,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [IW:0]   o_path_len
);

    state_t        r_state;
    state_t        w_next;

    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic          r_rd_en;
    logic [IW-1:0] r_rd_i;
    logic [IW-1:0] r_rd_j;
    logic          r_step_valid;
    logic [1:0]    r_step_dir;
    logic          r_step_match;
    logic          r_step_last;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [IW:0]   r_path_len;

    logic [1:0]    w_dec_dir;
    logic          w_dec_match;
    logic          w_dec_err;
    logic          w_origin;
    logic          w_interior;
    logic          w_accept;

    // Cell reached after moving from (i,j) in direction dir.
    function automatic logic [2*IW-1:0] f_move(input logic [IW-1:0] i,
                                               input logic [IW-1:0] j,
                                               input logic [1:0]    dir);
        logic [IW-1:0] ni;
        logic [IW-1:0] nj;
        ni = (dir == DIR_L) ? i : i - IW'(1);
        nj = (dir == DIR_U) ? j : j - IW'(1);
        return {ni, nj};
    endfunction

    // True when the move lands on the origin.
    function automatic logic f_is_last(input logic [IW-1:0] i,
                                       input logic [IW-1:0] j,
                                       input logic [1:0]    dir);
        return (f_move(i, j, dir) == '0);
    endfunction

    nw_traceback_decide #(
        .CW (CW),
        .SW (SW)
    ) u_decide (
        .i_cur     (i_rd_cur),
        .i_diag    (i_rd_diag),
        .i_up      (i_rd_up),
        .i_left    (i_rd_left),
        .i_chr_a   (i_chr_a),
        .i_chr_b   (i_chr_b),
        .o_dir_c   (w_dec_dir),
        .o_match_c (w_dec_match),
        .o_err_c   (w_dec_err)
    );

    assign w_origin   = (r_i == '0) && (r_j == '0);
    assign w_interior = (r_i != '0) && (r_j != '0);
    assign w_accept   = (r_state == S_EMIT) && i_step_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (i_start) w_next = S_CHECK;
            S_CHECK: begin
                if (w_origin)        w_next = S_DONE;
                else if (w_interior) w_next = S_ISSUE;
                else                 w_next = S_EDGE;
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_EMIT;
            S_EDGE:    w_next = S_EMIT;
            S_EMIT:    if (i_step_ready) w_next = r_step_last ? S_DONE : S_CHECK;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Registered outputs, cell indices and step payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i          <= '0;
            r_j          <= '0;
            r_rd_en      <= 1'b0;
            r_rd_i       <= '0;
            r_rd_j       <= '0;
            r_step_valid <= 1'b0;
            r_step_dir   <= 2'b00;
            r_step_match <= 1'b0;
            r_step_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_path_len   <= '0;
        end else begin
            r_rd_en      <= (w_next == S_ISSUE);
            r_step_valid <= (w_next == S_EMIT);
            r_busy       <= (w_next != S_IDLE);
            r_done       <= (w_next == S_DONE);

            if ((r_state == S_IDLE) && i_start) begin
                r_i        <= i_len_a;
                r_j        <= i_len_b;
                r_path_len <= '0;
                r_err      <= 1'b0;
            end

            if ((r_state == S_CHECK) && (w_next == S_ISSUE)) begin
                r_rd_i <= r_i - IW'(1);
                r_rd_j <= r_j - IW'(1);
            end

            if (r_state == S_CAPTURE) begin
                r_step_dir   <= w_dec_dir;
                r_step_match <= w_dec_match;
                r_step_last  <= f_is_last(r_i, r_j, w_dec_dir);
                r_err        <= r_err | w_dec_err;
            end

            if (r_state == S_EDGE) begin
                r_step_match <= 1'b0;
                if (r_i == '0) begin
                    r_step_dir  <= DIR_L;
                    r_step_last <= f_is_last(r_i, r_j, DIR_L);
                end else begin
                    r_step_dir  <= DIR_U;
                    r_step_last <= f_is_last(r_i, r_j, DIR_U);
                end
            end

            if (w_accept) begin
                {r_i, r_j} <= f_move(r_i, r_j, r_step_dir);
                r_path_len <= r_path_len + (IW+1)'(1);
            end
        end
    end

    assign o_rd_en      = r_rd_en;
    assign o_rd_i       = r_rd_i;
    assign o_rd_j       = r_rd_j;
    assign o_step_valid = r_step_valid;
    assign o_step_dir   = r_step_dir;
    assign o_step_match = r_step_match;
    assign o_step_last  = r_step_last;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_path_len   = r_path_len;

endmodule

// File: tb/tb_nw_traceback.sv
// Directed checks of nw_traceback against hand-built score matrices.
module tb_nw_traceback;

    localparam logic [1:0] D_DIR = 2'b01;
    localparam logic [1:0] U_DIR = 2'b10;
    localparam logic [1:0] L_DIR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_len_a = '0;
    logic [7:0]  i_len_b = '0;
    logic        o_rd_en;
    logic [7:0]  o_rd_i;
    logic [7:0]  o_rd_j;
    logic [8:0]  rd_cur;
    logic [8:0]  rd_diag;
    logic [8:0]  rd_up;
    logic [8:0]  rd_left;
    logic [1:0]  chr_a;
    logic [1:0]  chr_b;
    logic        o_step_valid;
    logic        i_step_ready = 1'b0;
    logic [1:0]  o_step_dir;
    logic        o_step_match;
    logic        o_step_last;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [8:0]  o_path_len;

    logic [8:0]  mat   [0:4][0:4];
    logic [1:0]  seq_a [0:3];
    logic [1:0]  seq_b [0:3];

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt   = 0;
    int sv_cnt   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    nw_traceback dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_len_a      (i_len_a),
        .i_len_b      (i_len_b),
        .o_rd_en      (o_rd_en),
        .o_rd_i       (o_rd_i),
        .o_rd_j       (o_rd_j),
        .i_rd_cur     (rd_cur),
        .i_rd_diag    (rd_diag),
        .i_rd_up      (rd_up),
        .i_rd_left    (rd_left),
        .i_chr_a      (chr_a),
        .i_chr_b      (chr_b),
        .o_step_valid (o_step_valid),
        .i_step_ready (i_step_ready),
        .o_step_dir   (o_step_dir),
        .o_step_match (o_step_match),
        .o_step_last  (o_step_last),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_path_len   (o_path_len)
    );

    // Score memory: the read address is held by the DUT through the capture cycle.
    always_comb begin
        int ri;
        int rj;
        ri      = int'(o_rd_i[1:0]);
        rj      = int'(o_rd_j[1:0]);
        rd_cur  = mat[ri+1][rj+1];
        rd_diag = mat[ri][rj];
        rd_up   = mat[ri][rj+1];
        rd_left = mat[ri+1][rj];
        chr_a   = seq_a[ri];
        chr_b   = seq_b[rj];
    end

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (o_rd_en)      rd_cnt   <= rd_cnt + 1;
        if (o_step_valid) sv_cnt   <= sv_cnt + 1;
        if (o_done)       done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_mat(input int i, input int j, input int v);
        mat[i][j] = 9'(v);
    endtask

    task automatic clear_mat();
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                mat[i][j] = '0;
        for (int k = 0; k < 4; k++) begin
            seq_a[k] = '0;
            seq_b[k] = '0;
        end
    endtask

    task automatic pulse_start(input int la, input int lb);
        @(negedge clk);
        i_start = 1'b1;
        i_len_a = 8'(la);
        i_len_b = 8'(lb);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!o_step_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take_step(input string tag, input int exp_lat, input logic [1:0] exp_dir,
                             input logic exp_match, input logic exp_last);
        int cyc;
        wait_valid(cyc);
        check_eq({tag, "_valid"}, 32'(o_step_valid), 1);
        check_eq({tag, "_lat"},   32'(cyc), 32'(exp_lat));
        check_eq({tag, "_dir"},   32'(o_step_dir), 32'(exp_dir));
        check_eq({tag, "_match"}, 32'(o_step_match), 32'(exp_match));
        check_eq({tag, "_last"},  32'(o_step_last), 32'(exp_last));
        i_step_ready = 1'b1;
        @(negedge clk);
        i_step_ready = 1'b0;
    endtask

    initial begin
        int rd0;
        int sv0;
        int dn0;
        int cyc;

        clear_mat();
        repeat (2) @(negedge clk);
        check_eq("rst_busy",  32'(o_busy), 0);
        check_eq("rst_valid", 32'(o_step_valid), 0);
        check_eq("rst_rd_en", 32'(o_rd_en), 0);
        check_eq("rst_done",  32'(o_done), 0);
        check_eq("rst_plen",  32'(o_path_len), 0);
        rst = 1'b0;
        @(negedge clk);

        // Empty sequences: done two cycles after start, nothing emitted.
        rd0 = rd_cnt; sv0 = sv_cnt;
        pulse_start(0, 0);
        check_eq("e0_busy", 32'(o_busy), 1);
        check_eq("e0_done_early", 32'(o_done), 0);
        @(negedge clk);
        check_eq("e0_done", 32'(o_done), 1);
        @(negedge clk);
        check_eq("e0_done_pulse", 32'(o_done), 0);
        check_eq("e0_idle", 32'(o_busy), 0);
        check_eq("e0_plen", 32'(o_path_len), 0);
        check_eq("e0_reads", 32'(rd_cnt - rd0), 0);
        check_eq("e0_steps", 32'(sv_cnt - sv0), 0);

        // Column edge only: two U steps, no reads.
        rd0 = rd_cnt;
        pulse_start(2, 0);
        take_step("u1", 2, U_DIR, 1'b0, 1'b0);
        take_step("u2", 2, U_DIR, 1'b0, 1'b1);
        check_eq("u_done", 32'(o_done), 1);
        check_eq("u_plen", 32'(o_path_len), 2);
        check_eq("u_reads", 32'(rd_cnt - rd0), 0);
        @(negedge clk);

        // A=B="GA": two matching diagonal steps.
        clear_mat();
        seq_a[0] = 2'd2; seq_a[1] = 2'd0;
        seq_b[0] = 2'd2; seq_b[1] = 2'd0;
        set_mat(0, 1, -2); set_mat(0, 2, -4);
        set_mat(1, 0, -2); set_mat(2, 0, -4);
        set_mat(1, 1, 1);  set_mat(1, 2, -1);
        set_mat(2, 1, -1); set_mat(2, 2, 2);
        rd0 = rd_cnt;
        pulse_start(2, 2);
        wait_valid(cyc);
        check_eq("ga_rd_i1", 32'(o_rd_i), 1);
        check_eq("ga_rd_j1", 32'(o_rd_j), 1);
        take_step("ga1", 0, D_DIR, 1'b1, 1'b0);
        wait_valid(cyc);
        check_eq("ga_lat2", 32'(cyc), 3);
        check_eq("ga_rd_i2", 32'(o_rd_i), 0);
        check_eq("ga_rd_j2", 32'(o_rd_j), 0);
        take_step("ga2", 0, D_DIR, 1'b1, 1'b1);
        check_eq("ga_done", 32'(o_done), 1);
        check_eq("ga_plen", 32'(o_path_len), 2);
        check_eq("ga_reads", 32'(rd_cnt - rd0), 2);
        @(negedge clk);

        // Interior latency on a fresh walk of the same matrix.
        pulse_start(2, 2);
        take_step("gl1", 3, D_DIR, 1'b1, 1'b0);
        take_step("gl2", 3, D_DIR, 1'b1, 1'b1);
        @(negedge clk);

        // A="G", B="GA": left gap then matching diagonal.
        clear_mat();
        seq_a[0] = 2'd2;
        seq_b[0] = 2'd2; seq_b[1] = 2'd0;
        set_mat(0, 1, -2); set_mat(0, 2, -4);
        set_mat(1, 0, -2); set_mat(1, 1, 1); set_mat(1, 2, -1);
        pulse_start(1, 2);
        take_step("gl_l", 3, L_DIR, 1'b0, 1'b0);
        take_step("gl_d", 3, D_DIR, 1'b1, 1'b1);
        check_eq("gl_plen", 32'(o_path_len), 2);
        @(negedge clk);

        // Tie between U and L: U wins; stalled consumer sees stable outputs.
        clear_mat();
        seq_a[0] = 2'd0; seq_b[0] = 2'd1;
        set_mat(0, 1, -2); set_mat(1, 0, -2); set_mat(1, 1, -4);
        pulse_start(1, 1);
        wait_valid(cyc);
        check_eq("tie_lat", 32'(cyc), 3);
        rd0 = rd_cnt;
        for (int k = 0; k < 5; k++) begin
            i_start = (k == 0);
            i_len_a = '0;
            i_len_b = '0;
            check_eq("tie_hold_valid", 32'(o_step_valid), 1);
            check_eq("tie_hold_dir",   32'(o_step_dir), 32'(U_DIR));
            check_eq("tie_hold_last",  32'(o_step_last), 0);
            @(negedge clk);
        end
        i_start = 1'b0;
        check_eq("tie_no_reads", 32'(rd_cnt - rd0), 0);
        take_step("tie_u", 0, U_DIR, 1'b0, 1'b0);
        take_step("tie_l", 2, L_DIR, 1'b0, 1'b1);
        check_eq("tie_plen", 32'(o_path_len), 2);
        @(negedge clk);

        // Corrupt cell: err raised, L emitted, walk still finishes.
        clear_mat();
        seq_a[0] = 2'd3; seq_b[0] = 2'd3;
        set_mat(0, 1, -2); set_mat(1, 0, -2); set_mat(1, 1, 7);
        pulse_start(1, 1);
        check_eq("bad_err_clear", 32'(o_err), 0);
        take_step("bad_l", 3, L_DIR, 1'b0, 1'b0);
        check_eq("bad_err", 32'(o_err), 1);
        take_step("bad_u", 2, U_DIR, 1'b0, 1'b1);
        check_eq("bad_done", 32'(o_done), 1);
        @(negedge clk);
        check_eq("bad_err_sticky", 32'(o_err), 1);
        pulse_start(0, 0);
        check_eq("bad_err_restart", 32'(o_err), 0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a walk aborts it without a done pulse.
        clear_mat();
        seq_a[0] = 2'd2; seq_a[1] = 2'd0;
        seq_b[0] = 2'd2; seq_b[1] = 2'd0;
        set_mat(1, 1, 1); set_mat(2, 2, 2);
        dn0 = done_cnt;
        pulse_start(2, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid_busy",  32'(o_busy), 0);
        check_eq("mid_rd_en", 32'(o_rd_en), 0);
        check_eq("mid_valid", 32'(o_step_valid), 0);
        check_eq("mid_rd_i",  32'(o_rd_i), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("mid_idle",    32'(o_busy), 0);
        check_eq("mid_no_done", 32'(done_cnt - dn0), 0);
        check_eq("mid_plen",    32'(o_path_len), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
